// File: rtl/rr_channel_arbiter_pkg.sv
// Shared handshake helpers for the round-robin channel arbiter.
// Constant-evaluable so it can size ports and internal vectors.
package rr_channel_arbiter_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority picker: first request at or after ptr, wrapping.
// Rotate via a doubled vector, then take the lowest set bit.
module rr_priority_select
  import rr_channel_arbiter_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int INDEX_TYPE = 1
) (
  input  logic [SIZE-1:0]       req,
  input  logic [INDEX_TYPE-1:0] ptr,
  output logic [SIZE-1:0]       grant_onehot,
  output logic [INDEX_TYPE-1:0] grant_idx,
  output logic                  any_grant
);

  localparam int W = clog2(SIZE);
  localparam logic [W:0] SZ = (W+1)'(SIZE);

  logic [SIZE-1:0] rot;
  logic [W:0]      off;
  logic [W:0]      sum;

  assign rot       = SIZE'({req, req} >> ptr);
  assign any_grant = |req;

  always_comb begin
    off = '0;
    for (int i = SIZE - 1; i >= 0; i--)
      if (rot[i]) off = (W+1)'(i);
  end

  // Offset is relative to ptr; fold back into 0..SIZE-1.
  always_comb begin
    sum = (W+1)'(ptr) + off;
    if (sum >= SZ) sum = sum - SZ;
  end

  assign grant_idx = INDEX_TYPE'(sum);

  always_comb begin
    grant_onehot = '0;
    if (any_grant) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin merge of SIZE elastic channels into one registered
// output slot carrying the winner's data and channel index.
module rr_channel_arbiter
  import rr_channel_arbiter_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic [INDEX_TYPE-1:0]     index,
  output logic                      outs_valid,
  input  logic                      outs_ready
);

  localparam logic [INDEX_TYPE-1:0] LAST = INDEX_TYPE'(SIZE - 1);

  logic                  full;
  logic [INDEX_TYPE-1:0] ptr;
  logic [DATA_TYPE-1:0]  data_q;
  logic [INDEX_TYPE-1:0] index_q;

  logic [SIZE-1:0]       grant_onehot;
  logic [INDEX_TYPE-1:0] grant_idx;
  logic                  any_grant;
  logic                  can_accept;
  logic                  push;
  logic [DATA_TYPE-1:0]  sel_data;

  rr_priority_select #(
    .SIZE       (SIZE),
    .INDEX_TYPE (INDEX_TYPE)
  ) u_sel (
    .req          (ins_valid),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  // Slot is free if empty or its token leaves this cycle.
  assign can_accept = !full || outs_ready;
  assign push       = any_grant && can_accept;
  assign ins_ready  = can_accept ? grant_onehot : '0;
  assign sel_data   = ins[grant_idx*DATA_TYPE +: DATA_TYPE];

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      ptr     <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else if (push) begin
      full    <= 1'b1;
      data_q  <= sel_data;
      index_q <= grant_idx;
      ptr     <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end else if (full && outs_ready) begin
      full <= 1'b0;
    end
  end

  assign outs_valid = full;
  assign outs       = data_q;
  assign index      = index_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Self-checking bench for rr_channel_arbiter, SIZE=4, against a
// cycle-level behavioural model of the round-robin merge slot.
module tb_rr_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] ins;
  logic [N-1:0]    ins_valid;
  logic [N-1:0]    ins_ready;
  logic [DW-1:0]   outs;
  logic [IW-1:0]   index;
  logic            outs_valid;
  logic            outs_ready;

  int checks = 0;
  int errors = 0;

  bit          m_full = 0;
  int          m_ptr  = 0;
  logic [31:0] m_data = '0;
  int          m_idx  = 0;

  always #5 clk = ~clk;

  rr_channel_arbiter #(
    .SIZE       (N),
    .DATA_TYPE  (DW),
    .INDEX_TYPE (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .index      (index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = model_grant(ins_valid, m_ptr);
    if (g >= 0 && (!m_full || outs_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_data();
    for (int i = 0; i < N; i++) ins[i*DW +: DW] = $urandom;
  endtask

  task automatic tick();
    int g;
    bit can;
    g = model_grant(ins_valid, m_ptr);
    can = !m_full || outs_ready;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_ptr = 0; m_data = '0; m_idx = 0;
    end else if (g >= 0 && can) begin
      m_full = 1;
      m_data = ins[g*DW +: DW];
      m_idx  = g;
      m_ptr  = (g + 1) % N;
    end else if (m_full && outs_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ins_valid = '1; outs_ready = 1; set_data();
    tick(); tick();
    rst = 0; ins_valid = '0;
    #3;
    checks++;
    if (outs_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", outs_valid);
    end
    checks++;
    if (outs !== '0 || index !== '0) begin
      errors++; $display("FAIL reset_data got %h/%0d want 0/0", outs, index);
    end
    checks++;
    if (ins_ready !== '0) begin
      errors++; $display("FAIL reset_ready got %b want 0000", ins_ready);
    end
    checks++;
    if (dut.ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr got %0d want 0", dut.ptr);
    end
  endtask

  task automatic test_round_robin();
    ins_valid = '1; outs_ready = 1;
    for (int c = 0; c < 8; c++) begin
      set_data();
      tick();
      checks++;
      if (outs_valid !== 1'b1 || index !== IW'(c % N) || outs !== m_data) begin
        errors++;
        $display("FAIL rr_seq c=%0d got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h",
                 c, outs_valid, index, outs, c % N, m_data);
      end
    end
  endtask

  task automatic test_single();
    ins_valid = 4'b0100; set_data();
    ins[2*DW +: DW] = 32'hA5;
    tick();
    checks++;
    if (outs !== 32'hA5 || index !== 2'd2 || dut.ptr !== 2'd3) begin
      errors++;
      $display("FAIL single got d=%h idx=%0d ptr=%0d want a5/2/3", outs, index, dut.ptr);
    end
    ins_valid = 4'b0110; set_data();
    #3;
    checks++;
    if (ins_ready !== 4'b0010) begin
      errors++; $display("FAIL single_next_ready got %b want 0010", ins_ready);
    end
    tick();
    checks++;
    if (index !== 2'd1 || outs !== m_data) begin
      errors++; $display("FAIL single_next got idx=%0d want 1", index);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ho;
    logic [IW-1:0] hi;
    ho = outs; hi = index;
    outs_ready = 0;
    for (int c = 0; c < 3; c++) begin
      ins_valid = N'($urandom_range(1, 15)); set_data();
      #3;
      checks++;
      if (ins_ready !== '0) begin
        errors++; $display("FAIL bp_ready got %b want 0000", ins_ready);
      end
      tick();
      checks++;
      if (outs !== ho || index !== hi || outs_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got %h/%0d/%b want %h/%0d/1", outs, index, outs_valid, ho, hi);
      end
    end
    outs_ready = 1; ins_valid = '1; set_data();
    #3;
    checks++;
    if (ins_ready !== exp_ready() || ins_ready === '0) begin
      errors++; $display("FAIL bp_release_ready got %b want %b", ins_ready, exp_ready());
    end
    tick();
    checks++;
    if (outs_valid !== 1'b1 || index !== IW'(m_idx) || outs !== m_data) begin
      errors++;
      $display("FAIL bp_refill got %0d/%h want %0d/%h", index, outs, m_idx, m_data);
    end
  endtask

  task automatic test_wrap();
    outs_ready = 1;
    ins_valid = 4'b0100; set_data();
    tick();
    ins_valid = 4'b1001; set_data();
    tick();
    checks++;
    if (index !== 2'd3 || dut.ptr !== 2'd0) begin
      errors++; $display("FAIL wrap got idx=%0d ptr=%0d want 3/0", index, dut.ptr);
    end
    set_data();
    tick();
    checks++;
    if (index !== 2'd0 || outs !== m_data) begin
      errors++; $display("FAIL wrap_next got idx=%0d want 0", index);
    end
  endtask

  task automatic test_mid_reset();
    outs_ready = 1;
    ins_valid = 4'b0010; set_data();
    tick();
    checks++;
    if (index !== 2'd1 || outs_valid !== 1'b1) begin
      errors++; $display("FAIL mr_pre got idx=%0d v=%b want 1/1", index, outs_valid);
    end
    outs_ready = 0; rst = 1;
    tick();
    rst = 0; ins_valid = '0;
    #3;
    checks++;
    if (outs_valid !== 1'b0 || dut.ptr !== 2'd0) begin
      errors++; $display("FAIL mr_idle got v=%b ptr=%0d want 0/0", outs_valid, dut.ptr);
    end
    ins_valid = '1; set_data();
    #1;
    checks++;
    if (ins_ready !== 4'b0001) begin
      errors++; $display("FAIL mr_ready got %b want 0001", ins_ready);
    end
    tick();
    checks++;
    if (index !== 2'd0 || outs !== m_data) begin
      errors++; $display("FAIL mr_first got idx=%0d want 0", index);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      ins_valid  = N'($urandom);
      outs_ready = ($urandom_range(0, 3) != 0);
      set_data();
      #3;
      checks++;
      if (ins_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, ins_ready, exp_ready());
      end
      tick();
      checks++;
      if (outs_valid !== m_full || outs !== m_data || index !== IW'(m_idx)) begin
        errors++;
        $display("FAIL rnd_out c=%0d got %b/%h/%0d want %b/%h/%0d",
                 c, outs_valid, outs, index, m_full, m_data, m_idx);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; ins = '0; ins_valid = '0; outs_ready = 0;
    #1;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
